mux_arb_nto1: RTL and testbench
===============================

# mux_arb_nto1

Parametrised N-input, WIDTH-bit arbitrated multiplexer with per-channel valid/ready handshakes and a registered output stage. Arbitration is round-robin or fixed-priority. The block generalises the fixed 2/4/8-way select muxes: the select is produced internally by an arbiter, not driven externally. It sits between multiple requesters (e.g. fetch/load-store/debug ports) and a single shared consumer such as the memory or bus port.

## Interface
- NUM_IN, 4: number of input channels, 2..16.
- WIDTH, 32: data width in bits, ≥1.
- RR_EN, 1: 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
- SEL_W, $clog2(NUM_IN): width of the channel index. Derived; not overridden.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  NUM_IN  per-channel request.
- in_data  in  NUM_IN×WIDTH  packed; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  NUM_IN  per-channel accept; at most one bit high.
- out_valid  out  1  output register holds a beat.
- out_data  out  WIDTH  registered selected data.
- out_sel  out  SEL_W  index of the channel that produced out_data.
- out_ready  in  1  consumer accepts the beat.

## Operation
- load = !out_valid || out_ready. The output register accepts a new beat only when load=1.
- The arbiter selects grant g from in_valid:
  - RR_EN=1: the first asserted bit at or above pointer ptr, wrapping modulo NUM_IN.
  - RR_EN=0: the lowest asserted index.
- in_ready[g] = load && in_valid[g] && !rst. All other in_ready bits are 0. No in_valid high gives in_ready = 0.
- Transfer on channel g occurs when in_valid[g] && in_ready[g]. On the next edge:
  - out_data ← in_data[g]
  - out_sel ← g
  - out_valid ← 1
  - RR_EN=1 only: ptr ← (g+1) mod NUM_IN. Wrap from NUM_IN−1 goes to 0.
- load=1 with no transfer: out_valid ← 0. out_data and out_sel hold their values.
- ptr changes only on a transfer. Unserved requesters keep priority.
- Output stall (out_valid && !out_ready): out_data, out_sel and out_valid hold. All in_ready are 0.
- Simultaneous drain and refill (out_valid && out_ready && an input valid): a new beat is loaded the same edge. Sustained throughput is 1 beat/cycle.
- Requesters must hold in_valid and in_data until accepted. The block does not check this.
- Non-power-of-two NUM_IN: ptr never takes values ≥ NUM_IN. Wrap is explicit modulo, not a bit-width overflow.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=0, in_ready=0.
- Reset mid-operation: a beat held in the output register is discarded. A beat presented in the reset cycle is not accepted, because in_ready is forced to 0.
- Latency: a transfer at edge N gives out_valid=1 with that data from edge N until the consumer accepts it.
- in_ready is combinational from in_valid, out_valid and out_ready. There is a combinational path out_ready→in_ready; consumers must not derive out_ready from in_ready.
- out_* are registered; there is no combinational path from inputs to out_*.

## Structure
- Shared package mux_pkg:
  - typedef arb_mode_e with values ARB_FIXED and ARB_RR.
  - Helper function for the one-hot-to-index conversion.
- Sub-module rr_arbiter #(NUM_IN, RR_EN):
  - Inputs: req, ptr.
  - Outputs: grant_onehot, grant_idx, any_grant.
  - Purely combinational.
- The top-level module holds ptr, the output register and the handshake logic.
- The data selection is a one-hot AND-OR over in_data using grant_onehot.

## Test plan
1. Reset: hold rst=1 for 2 cycles with all in_valid=1 → in_ready=0, out_valid=0, out_data=0, out_sel=0. After release, the first grant is to channel 0.
2. Round-robin fairness, NUM_IN=4, RR_EN=1, out_ready=1, all in_valid=1, in_data[i]=32'hA0+i:
   - out_sel sequence is 0,1,2,3,0.
   - out_data is A0,A1,A2,A3,A0.
   - One beat per cycle.
3. Fixed priority, RR_EN=0, in_valid=4'b1010 held for 3 cycles → out_sel=1 every beat. Dropping in_valid[1] → the next beat is out_sel=3.
4. Backpressure:
   - After a beat from channel 2 (data 32'hDEAD_BEEF), hold out_ready=0 for 5 cycles → out_data/out_sel stable and in_ready=0.
   - Then raise out_ready with in_valid[3]=1 → DEADBEEF is accepted, and channel 3 data appears the next cycle with no bubble.
5. Wrap and skip, NUM_IN=3, RR_EN=1:
   - After a grant to channel 2, ptr=0.
   - With in_valid=3'b100 → grant to 2 again.
   - With in_valid=3'b011 and ptr=2 → grant 0, then 1.
6. Reset mid-stall: out_valid=1, out_ready=0, assert rst for 1 cycle → out_valid=0, out_sel=0, ptr=0, and the held beat is dropped.

Source files
------------

// File: rtl/mux_pkg.sv
// ============================================================================
// Module   : mux_pkg
// Purpose  : Shared types and helpers for the arbitrated N-to-1 multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int MAX_IN    = 16;
  localparam int MAX_SEL_W = 4;

  // OR-reduction encoder; correct only for one-hot or all-zero input.
  function automatic logic [MAX_SEL_W-1:0] onehot_to_idx(input logic [MAX_IN-1:0] oh);
    logic [MAX_SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_IN; i++) begin
      if (oh[i]) idx = idx | MAX_SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_arb_nto1_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin / fixed-priority grant generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int RR_EN  = 1,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant_onehot,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              any_grant
);

  localparam arb_mode_e MODE = (RR_EN != 0) ? ARB_RR : ARB_FIXED;

  logic [MAX_IN-1:0] oh_ext;

  // Scan from ptr upward (or from 0 in fixed mode); the first request wins.
  always_comb begin
    logic [SEL_W-1:0] idx;
    logic             found;
    grant_onehot = '0;
    found        = 1'b0;
    idx          = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (MODE == ARB_RR) begin
        idx = SEL_W'((int'(ptr) + k) % NUM_IN);
      end else begin
        idx = SEL_W'(k);
      end
      if (!found && req[idx]) begin
        grant_onehot[idx] = 1'b1;
        found             = 1'b1;
      end
    end
  end

  always_comb begin
    oh_ext               = '0;
    oh_ext[NUM_IN-1:0]   = grant_onehot;
  end

  assign grant_idx = SEL_W'(onehot_to_idx(oh_ext));
  assign any_grant = |req;

endmodule

`default_nettype wire

// File: rtl/mux_arb_nto1.sv
// ============================================================================
// Module   : mux_arb_nto1
// Purpose  : N-input arbitrated mux with valid/ready handshakes and a
//            registered output stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_arb_nto1
  import mux_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 32,
  parameter int RR_EN  = 1,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  localparam arb_mode_e MODE = (RR_EN != 0) ? ARB_RR : ARB_FIXED;

  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;

  logic [NUM_IN-1:0] grant_onehot;
  logic [SEL_W-1:0]  grant_idx;
  logic              any_grant;
  logic              load;
  logic              xfer;
  logic [WIDTH-1:0]  sel_data;

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .RR_EN  (RR_EN)
  ) u_arb (
    .req          (in_valid),
    .ptr          (ptr_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any_grant    (any_grant)
  );

  assign load     = !out_valid_q || out_ready;
  assign in_ready = (load && any_grant && !rst) ? grant_onehot : '0;
  assign xfer     = |in_ready;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_onehot[i]}});
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = sel_data;
        out_sel_d  = grant_idx;
      end
    end
    // Explicit wrap keeps ptr below NUM_IN for non-power-of-two widths.
    if ((MODE == ARB_RR) && xfer) begin
      ptr_d = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_arb_nto1.sv
// ============================================================================
// Module   : tb_mux_arb_nto1
// Purpose  : Directed self-checking bench for mux_arb_nto1 (RR, fixed, N=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_arb_nto1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Round-robin, N=4
  logic [3:0]    a_iv, a_ir;
  logic [127:0]  a_id;
  logic          a_ov, a_or;
  logic [31:0]   a_od;
  logic [1:0]    a_os;
  // Fixed priority, N=4
  logic [3:0]    f_iv, f_ir;
  logic [127:0]  f_id;
  logic          f_ov, f_or;
  logic [31:0]   f_od;
  logic [1:0]    f_os;
  // Round-robin, N=3
  logic [2:0]    t_iv, t_ir;
  logic [95:0]   t_id;
  logic          t_ov, t_or;
  logic [31:0]   t_od;
  logic [1:0]    t_os;

  mux_arb_nto1 #(.NUM_IN(4), .WIDTH(32), .RR_EN(1)) u_rr4 (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
    .out_valid(a_ov), .out_data(a_od), .out_sel(a_os), .out_ready(a_or));

  mux_arb_nto1 #(.NUM_IN(4), .WIDTH(32), .RR_EN(0)) u_fix4 (
    .clk(clk), .rst(rst), .in_valid(f_iv), .in_data(f_id), .in_ready(f_ir),
    .out_valid(f_ov), .out_data(f_od), .out_sel(f_os), .out_ready(f_or));

  mux_arb_nto1 #(.NUM_IN(3), .WIDTH(32), .RR_EN(1)) u_rr3 (
    .clk(clk), .rst(rst), .in_valid(t_iv), .in_data(t_id), .in_ready(t_ir),
    .out_valid(t_ov), .out_data(t_od), .out_sel(t_os), .out_ready(t_or));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    a_iv = 4'b1111; a_or = 1'b1;
    a_id = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    step(); step();
    checks++; if (a_ir !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", a_ir); end
    checks++; if (a_ov !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", a_ov); end
    checks++; if (a_od !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", a_od); end
    checks++; if (a_os !== 2'd0) begin failures++; $display("FAIL reset_out_sel got=%0d exp=0", a_os); end
    checks++; if (f_ov !== 1'b0 || t_ov !== 1'b0) begin failures++; $display("FAIL reset_other_valid got=%b%b exp=00", f_ov, t_ov); end
    rst = 1'b0;
    #1;
    checks++; if (a_ir !== 4'b0001) begin failures++; $display("FAIL first_grant got=%b exp=0001", a_ir); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_sel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] exp_dat [5] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0};
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (a_ov !== 1'b1) begin failures++; $display("FAIL rr_valid beat=%0d got=%b exp=1", i, a_ov); end
      checks++; if (a_os !== exp_sel[i]) begin failures++; $display("FAIL rr_sel beat=%0d got=%0d exp=%0d", i, a_os, exp_sel[i]); end
      checks++; if (a_od !== exp_dat[i]) begin failures++; $display("FAIL rr_data beat=%0d got=%h exp=%h", i, a_od, exp_dat[i]); end
    end
    a_iv = 4'b0000;
    step();
    checks++; if (a_ov !== 1'b0) begin failures++; $display("FAIL rr_idle_valid got=%b exp=0", a_ov); end
    checks++; if (a_od !== 32'hA0 || a_os !== 2'd0) begin failures++; $display("FAIL rr_idle_hold got=%h/%0d exp=000000a0/0", a_od, a_os); end
  endtask

  task automatic test_fixed_priority();
    f_or = 1'b1;
    f_id = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    f_iv = 4'b1010;
    #1;
    checks++; if (f_ir !== 4'b0010) begin failures++; $display("FAIL fix_ready got=%b exp=0010", f_ir); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (f_os !== 2'd1 || f_od !== 32'hB1 || f_ov !== 1'b1) begin
        failures++; $display("FAIL fix_beat beat=%0d got=%0d/%h/%b exp=1/000000b1/1", i, f_os, f_od, f_ov); end
    end
    f_iv = 4'b1000;
    #1;
    checks++; if (f_ir !== 4'b1000) begin failures++; $display("FAIL fix_ready3 got=%b exp=1000", f_ir); end
    step();
    checks++; if (f_os !== 2'd3 || f_od !== 32'hB3) begin failures++; $display("FAIL fix_drop got=%0d/%h exp=3/000000b3", f_os, f_od); end
    f_iv = 4'b0000;
  endtask

  task automatic test_backpressure();
    // ptr is 1 after the round-robin run; ch2 is the only requester.
    a_or = 1'b1;
    a_id = {32'hC3, 32'hDEAD_BEEF, 32'hA1, 32'hA0};
    a_iv = 4'b0100;
    step();
    checks++; if (a_os !== 2'd2 || a_od !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bp_load got=%0d/%h exp=2/deadbeef", a_os, a_od); end
    a_iv = 4'b1000; a_or = 1'b0;
    #1;
    checks++; if (a_ir !== 4'b0000) begin failures++; $display("FAIL bp_stall_ready got=%b exp=0000", a_ir); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (a_ov !== 1'b1 || a_os !== 2'd2 || a_od !== 32'hDEAD_BEEF || a_ir !== 4'b0000) begin
        failures++; $display("FAIL bp_hold cyc=%0d got=%b/%0d/%h/%b exp=1/2/deadbeef/0000", i, a_ov, a_os, a_od, a_ir); end
    end
    a_or = 1'b1;
    #1;
    checks++; if (a_ir !== 4'b1000) begin failures++; $display("FAIL bp_release_ready got=%b exp=1000", a_ir); end
    step();
    checks++; if (a_ov !== 1'b1 || a_os !== 2'd3 || a_od !== 32'hC3) begin failures++; $display("FAIL bp_no_bubble got=%b/%0d/%h exp=1/3/000000c3", a_ov, a_os, a_od); end
    a_iv = 4'b0000;
  endtask

  task automatic test_wrap_skip();
    t_or = 1'b1;
    t_id = {32'hD2, 32'hD1, 32'hD0};
    t_iv = 3'b100;
    step();
    checks++; if (t_os !== 2'd2 || t_od !== 32'hD2) begin failures++; $display("FAIL wrap_first got=%0d/%h exp=2/000000d2", t_os, t_od); end
    #1;
    checks++; if (t_ir !== 3'b100) begin failures++; $display("FAIL wrap_again_ready got=%b exp=100", t_ir); end
    step();
    t_iv = 3'b111;
    #1;
    checks++; if (t_ir !== 3'b001) begin failures++; $display("FAIL wrap_ptr0 got=%b exp=001", t_ir); end
    step();
    t_iv = 3'b010;
    step();
    checks++; if (t_os !== 2'd1) begin failures++; $display("FAIL wrap_to_ptr2 got=%0d exp=1", t_os); end
    t_iv = 3'b011;
    #1;
    checks++; if (t_ir !== 3'b001) begin failures++; $display("FAIL skip_ready got=%b exp=001", t_ir); end
    step();
    checks++; if (t_os !== 2'd0 || t_od !== 32'hD0) begin failures++; $display("FAIL skip_beat0 got=%0d/%h exp=0/000000d0", t_os, t_od); end
    step();
    checks++; if (t_os !== 2'd1 || t_od !== 32'hD1) begin failures++; $display("FAIL skip_beat1 got=%0d/%h exp=1/000000d1", t_os, t_od); end
    t_iv = 3'b000;
  endtask

  task automatic test_reset_mid_stall();
    // ptr is 0 after the ch3 beat; a ch1 beat moves it to 2.
    a_or = 1'b1;
    a_id = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    a_iv = 4'b0010;
    step();
    a_iv = 4'b0000; a_or = 1'b0;
    step();
    checks++; if (a_ov !== 1'b1 || a_os !== 2'd1) begin failures++; $display("FAIL mid_stall_pre got=%b/%0d exp=1/1", a_ov, a_os); end
    rst = 1'b1; a_iv = 4'b1111;
    #1;
    checks++; if (a_ir !== 4'b0000) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0000", a_ir); end
    step();
    checks++; if (a_ov !== 1'b0 || a_os !== 2'd0 || a_od !== 32'h0) begin failures++; $display("FAIL mid_rst_out got=%b/%0d/%h exp=0/0/0", a_ov, a_os, a_od); end
    rst = 1'b0; a_or = 1'b1;
    #1;
    checks++; if (a_ir !== 4'b0001) begin failures++; $display("FAIL mid_rst_ptr got=%b exp=0001", a_ir); end
    step();
    checks++; if (a_os !== 2'd0 || a_od !== 32'hA0) begin failures++; $display("FAIL mid_rst_beat got=%0d/%h exp=0/000000a0", a_os, a_od); end
    a_iv = 4'b0000;
  endtask

  initial begin
    a_iv = '0; a_id = '0; a_or = 1'b0;
    f_iv = '0; f_id = '0; f_or = 1'b0;
    t_iv = '0; t_id = '0; t_or = 1'b0;
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_wrap_skip();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
